force_cache_access_scheduler: RTL and testbench
===============================================

FORCE_CACHE_ACCESS_SCHEDULER -- requirements
Module: force_cache_access_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of one force component (IEEE-754 single).
REQ-002 Parameter NUM_REQ, 4, number of force-evaluation pipelines sharing one write-back controller.
REQ-003 Parameter CELL_ADDR_WIDTH, 9, particle address width within a cell.
REQ-004 Parameter PARTICLE_ID_WIDTH, 21, {cell_x, cell_y, cell_z, address} width, 3x4 bits plus CELL_ADDR_WIDTH.
REQ-005 Parameter DRAIN_CYCLES, 24, idle cycles covering the write-back buffer depth (16) plus its accumulate/write-back latency (7) plus 1.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 in_req_valid  in  NUM_REQ  per-requester partial-force valid.
REQ-009 in_req_particle_id  in  NUM_REQ*PARTICLE_ID_WIDTH  per-requester target particle ID, requester i at slice i.
REQ-010 in_req_force  in  NUM_REQ*3*DATA_WIDTH  per-requester {Fz, Fy, Fx}.
REQ-011 out_req_ready  out  NUM_REQ  one-hot grant; transfer occurs when valid and ready are both high.
REQ-012 in_start_readout  in  1  single-cycle pulse requesting cache drain and readout.
REQ-013 in_particle_count  in  CELL_ADDR_WIDTH  number of particles to read; sampled with in_start_readout.
REQ-014 out_partial_force_valid / out_particle_id / out_partial_force  out  1 / PARTICLE_ID_WIDTH / 3*DATA_WIDTH  to write-back controller force input.
REQ-015 out_read_data_request / out_cache_read_address  out  1 / CELL_ADDR_WIDTH  to write-back controller read port.
REQ-016 out_busy / out_readout_done  out  1 / 1  not-in-ACCUM indicator; one-cycle completion pulse.

Function
REQ-017 FSM states: ACCUM, DRAIN, READOUT, DONE; reset state ACCUM.
REQ-018 ACCUM: at most one grant per cycle; out_req_ready is combinational, one-hot, and asserted only for the selected valid requester.
REQ-019 A granted transfer appears on out_partial_force_valid/id/force exactly 1 cycle later (registered); otherwise out_partial_force_valid is 0 and the data outputs hold their values.
REQ-020 Requests are never dropped; an ungranted requester holds its data until ready.
REQ-021 ACCUM + in_start_readout: no grant in that cycle or afterwards; the scheduler latches in_particle_count and enters DRAIN next cycle.
REQ-022 DRAIN: the counter loads DRAIN_CYCLES-1 on entry and decrements each cycle; at 0 it enters READOUT, or DONE if the latched count is 0.
REQ-023 READOUT: out_read_data_request is 1 and out_cache_read_address steps 1, 2, ... count, one per cycle; after the cycle that presents count, the next state is DONE.
REQ-024 DONE: out_readout_done is 1 for exactly one cycle, then the FSM returns to ACCUM.
REQ-025 out_read_data_request and out_partial_force_valid are never high in the same cycle.
REQ-026 in_start_readout outside ACCUM is ignored.
REQ-027 The address counter is CELL_ADDR_WIDTH wide; count = 2^CELL_ADDR_WIDTH-1 ends without wrapping to 0.

Reset
REQ-028 Asynchronous assertion: the FSM goes to ACCUM; all counters, the latched count and the round-robin pointer go to 0; every output goes to 0.
REQ-029 Reset mid-DRAIN or mid-READOUT abandons the sequence with no done pulse; deassertion takes effect synchronously on the next clk edge.

Configuration
REQ-030 Macro FORCE_SCHED_ROUND_ROBIN_EN defined: round-robin arbitration; the pointer advances to one past the last granted index, and the search starts at the pointer.
REQ-031 Macro FORCE_SCHED_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; there is no pointer register.

Structure
REQ-032 Shared package force_sched_pkg holds the state enum, default widths and DRAIN_CYCLES default.
REQ-033 A single sub-module, force_req_arbiter, implements the NUM_REQ grant logic, including the macro-selected policy.

Verification
REQ-034 Single requester 0, ID {2,2,2,5}, force 1.0 x3 (3F800000) -> ready0 same cycle; outputs valid 1 cycle later with identical ID/force.
REQ-035 All 4 requesters valid continuously for 8 cycles, macro defined -> grants 0,1,2,3,0,1,2,3; macro undefined -> grant 0 every cycle.
REQ-036 in_start_readout with count 3 while requesters valid -> ready low from that cycle; 24 DRAIN cycles; read addresses 1,2,3; done pulse; ACCUM resumes.
REQ-037 in_start_readout with count 0 -> DRAIN of 24 cycles, no read request, done pulse, then ACCUM.
REQ-038 Reset asserted at READOUT address 2 of 5 -> all outputs 0 immediately; no done pulse; ACCUM after release.
REQ-039 Second in_start_readout during DRAIN -> ignored; a single readout sequence and a single done pulse.

Source files
------------

// File: rtl/force_cache_access_scheduler_pkg.sv
// force_sched_pkg: definitions shared by the force cache access scheduler
// and its request arbiter.
//   - default widths and the drain length used as parameter defaults
//   - sched_state_e: scheduler FSM state encoding
//   - ptr_width(): width of an index register over N requesters
// Optional feature macro FORCE_SCHED_ROUND_ROBIN_EN is consumed by
// force_req_arbiter; nothing in this package depends on it.
package force_sched_pkg;

    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_NUM_REQ           = 4;
    localparam int DEF_CELL_ADDR_WIDTH   = 9;
    localparam int DEF_PARTICLE_ID_WIDTH = 21;
    // Write-back buffer depth (16) + accumulate/write-back latency (7) + 1.
    localparam int DEF_DRAIN_CYCLES      = 24;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_READOUT = 2'd2,
        ST_DONE    = 2'd3
    } sched_state_e;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/force_cache_access_scheduler_arbiter.sv
// force_req_arbiter: one-hot grant over NUM_REQ requesters.
// Policy is selected by macro FORCE_SCHED_ROUND_ROBIN_EN:
//   defined   - round robin; search starts at the pointer, pointer moves to
//               one past the granted index (clk/rst ports exist only here)
//   undefined - fixed priority, lowest index wins, purely combinational
// Ports:
//   clk, rst  in   clock and asynchronous active-low reset (round robin only)
//   req       in   NUM_REQ request vector (already qualified by the caller)
//   grant     out  NUM_REQ one-hot grant, combinational from req
module force_req_arbiter
    import force_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
`ifdef FORCE_SCHED_ROUND_ROBIN_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);

`ifdef FORCE_SCHED_ROUND_ROBIN_EN
    localparam int PTR_W = ptr_width(NUM_REQ);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Pick the requester with the smallest rotational distance from ptr_q.
    always_comb begin
        int best_dist;
        int dist;
        grant     = '0;
        ptr_d     = ptr_q;
        best_dist = NUM_REQ;
        dist      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dist = (i - int'(ptr_q) + NUM_REQ) % NUM_REQ;
            if (req[i] && (dist < best_dist)) begin
                best_dist = dist;
                grant     = '0;
                grant[i]  = 1'b1;
                ptr_d     = PTR_W'((i + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Isolate the lowest set bit.
    assign grant = req & (-req);
`endif

endmodule

// File: rtl/force_cache_access_scheduler.sv
// force_cache_access_scheduler: shares one write-back controller between
// NUM_REQ force pipelines, then drains the write-back path and reads the
// cache out on request.
// Arbitration policy: macro FORCE_SCHED_ROUND_ROBIN_EN (see force_req_arbiter).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   in_req_valid/particle_id/force, out_req_ready   requester handshake
//   in_start_readout, in_particle_count             readout request (pulse)
//   out_partial_force_valid/out_particle_id/out_partial_force  to controller
//   out_read_data_request, out_cache_read_address   controller read port
//   out_busy, out_readout_done                      status
module force_cache_access_scheduler
    import force_sched_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int NUM_REQ           = DEF_NUM_REQ,
    parameter int CELL_ADDR_WIDTH   = DEF_CELL_ADDR_WIDTH,
    parameter int PARTICLE_ID_WIDTH = DEF_PARTICLE_ID_WIDTH,
    parameter int DRAIN_CYCLES      = DEF_DRAIN_CYCLES
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  in_req_valid,
    input  logic [NUM_REQ*PARTICLE_ID_WIDTH-1:0] in_req_particle_id,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]     in_req_force,
    output logic [NUM_REQ-1:0]                  out_req_ready,
    input  logic                                in_start_readout,
    input  logic [CELL_ADDR_WIDTH-1:0]          in_particle_count,
    output logic                                out_partial_force_valid,
    output logic [PARTICLE_ID_WIDTH-1:0]        out_particle_id,
    output logic [3*DATA_WIDTH-1:0]             out_partial_force,
    output logic                                out_read_data_request,
    output logic [CELL_ADDR_WIDTH-1:0]          out_cache_read_address,
    output logic                                out_busy,
    output logic                                out_readout_done
);

    localparam int FORCE_W = 3 * DATA_WIDTH;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    sched_state_e               state_q, state_d;
    logic [DRAIN_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic [CELL_ADDR_WIDTH-1:0] count_q, count_d;
    logic [CELL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       pf_valid_q, pf_valid_d;
    logic [PARTICLE_ID_WIDTH-1:0] pf_id_q, pf_id_d;
    logic [FORCE_W-1:0]         pf_force_q, pf_force_d;

    logic [NUM_REQ-1:0]           req_masked;
    logic [NUM_REQ-1:0]           grant;
    logic [PARTICLE_ID_WIDTH-1:0] id_slice [NUM_REQ];
    logic [FORCE_W-1:0]           force_slice [NUM_REQ];
    logic [PARTICLE_ID_WIDTH-1:0] sel_id;
    logic [FORCE_W-1:0]           sel_force;

    // A start pulse closes the grant window in the same cycle it arrives.
    assign req_masked = ((state_q == ST_ACCUM) && !in_start_readout) ? in_req_valid : '0;

    force_req_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
`ifdef FORCE_SCHED_ROUND_ROBIN_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .req     (req_masked),
        .grant   (grant)
    );

    // Ready is combinational, so gate it with reset to keep it low while held.
    assign out_req_ready = grant & {NUM_REQ{rst}};

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign id_slice[gi]    = in_req_particle_id[gi*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH];
        assign force_slice[gi] = in_req_force[gi*FORCE_W +: FORCE_W];
    end

    // Grant is one-hot, so an AND-OR mux is sufficient.
    always_comb begin
        sel_id    = '0;
        sel_force = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_id    = sel_id | id_slice[i];
                sel_force = sel_force | force_slice[i];
            end
        end
    end

    always_comb begin
        pf_valid_d = |grant;
        pf_id_d    = (|grant) ? sel_id : pf_id_q;
        pf_force_d = (|grant) ? sel_force : pf_force_q;
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        count_d     = count_q;
        addr_d      = addr_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_start_readout) begin
                    count_d     = in_particle_count;
                    drain_cnt_d = DRAIN_W'(DRAIN_CYCLES - 1);
                    state_d     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == '0) begin
                    if (count_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READOUT;
                        addr_d  = CELL_ADDR_WIDTH'(1);
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_READOUT: begin
                // Compare before incrementing so a full-range count never wraps.
                if (addr_q == count_q) begin
                    state_d = ST_DONE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + CELL_ADDR_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_ACCUM;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACCUM;
            drain_cnt_q <= '0;
            count_q     <= '0;
            addr_q      <= '0;
            pf_valid_q  <= 1'b0;
            pf_id_q     <= '0;
            pf_force_q  <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            pf_valid_q  <= pf_valid_d;
            pf_id_q     <= pf_id_d;
            pf_force_q  <= pf_force_d;
        end
    end

    assign out_partial_force_valid = pf_valid_q;
    assign out_particle_id         = pf_id_q;
    assign out_partial_force       = pf_force_q;
    assign out_read_data_request   = (state_q == ST_READOUT);
    assign out_cache_read_address  = (state_q == ST_READOUT) ? addr_q : '0;
    assign out_busy                = (state_q != ST_ACCUM);
    assign out_readout_done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_force_cache_access_scheduler.sv
// Directed testbench for force_cache_access_scheduler (default parameters).
// Expected grant orders follow FORCE_SCHED_ROUND_ROBIN_EN as compiled.
module tb_force_cache_access_scheduler;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int AW  = 9;
    localparam int PW  = 21;
    localparam int FW  = 3 * DW;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     in_req_valid;
    logic [NR*PW-1:0]  in_req_particle_id;
    logic [NR*FW-1:0]  in_req_force;
    logic [NR-1:0]     out_req_ready;
    logic              in_start_readout;
    logic [AW-1:0]     in_particle_count;
    logic              out_partial_force_valid;
    logic [PW-1:0]     out_particle_id;
    logic [FW-1:0]     out_partial_force;
    logic              out_read_data_request;
    logic [AW-1:0]     out_cache_read_address;
    logic              out_busy;
    logic              out_readout_done;

    logic [PW-1:0] tb_id    [NR];
    logic [FW-1:0] tb_force [NR];

    int checks   = 0;
    int failures = 0;

    force_cache_access_scheduler dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_req_valid            (in_req_valid),
        .in_req_particle_id      (in_req_particle_id),
        .in_req_force            (in_req_force),
        .out_req_ready           (out_req_ready),
        .in_start_readout        (in_start_readout),
        .in_particle_count       (in_particle_count),
        .out_partial_force_valid (out_partial_force_valid),
        .out_particle_id         (out_particle_id),
        .out_partial_force       (out_partial_force),
        .out_read_data_request   (out_read_data_request),
        .out_cache_read_address  (out_cache_read_address),
        .out_busy                (out_busy),
        .out_readout_done        (out_readout_done)
    );

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign in_req_particle_id[gi*PW +: PW] = tb_id[gi];
        assign in_req_force[gi*FW +: FW]       = tb_force[gi];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [NR-1:0] valid;
        logic [NR-1:0] exp_fixed;
        logic [NR-1:0] exp_rr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int idx_of(input logic [NR-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    // Runs through DRAIN, returning the number of cycles spent there.
    // restart_at >= 0 pulses a second start request on that drain cycle.
    task automatic wait_drain(input int restart_at, output int n);
        n = 0;
        while (!out_read_data_request && !out_readout_done && n < 100) begin
            check("drain_ready_low", out_req_ready, 0);
            if (n == restart_at) begin
                in_start_readout  = 1'b1;
                in_particle_count = 9'd7;
            end
            n++;
            tick();
            in_start_readout = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, out_req_ready, 0);
        check({tag, "_pf_valid"}, out_partial_force_valid, 0);
        check({tag, "_pf_id"}, out_particle_id, 0);
        check({tag, "_pf_force"}, out_partial_force, 0);
        check({tag, "_rd_req"}, out_read_data_request, 0);
        check({tag, "_rd_addr"}, out_cache_read_address, 0);
        check({tag, "_busy"}, out_busy, 0);
        check({tag, "_done"}, out_readout_done, 0);
    endtask

    initial begin
        int n;
        int dones;
        int rds;
        logic [NR-1:0] exp;

        // Round-robin expectations assume the pointer is 1 on entry
        // (requester 0 was granted just before the table).
        vecs[0] = '{4'b1111, 4'b0001, 4'b0010};
        vecs[1] = '{4'b0110, 4'b0010, 4'b0100};
        vecs[2] = '{4'b1001, 4'b0001, 4'b1000};
        vecs[3] = '{4'b1100, 4'b0100, 4'b0100};
        vecs[4] = '{4'b0011, 4'b0001, 4'b0001};
        vecs[5] = '{4'b0000, 4'b0000, 4'b0000};
        vecs[6] = '{4'b1000, 4'b1000, 4'b1000};

        tb_id[0]    = {4'd2, 4'd2, 4'd2, 9'd5};
        tb_force[0] = {3{32'h3F80_0000}};
        for (int i = 1; i < NR; i++) begin
            tb_id[i]    = {4'(i + 1), 4'(i + 2), 4'(i + 3), 9'(10 + i)};
            tb_force[i] = {3{32'h4000_0000 + 32'(i)}};
        end

        rst               = 1'b0;
        in_req_valid      = '0;
        in_start_readout  = 1'b0;
        in_particle_count = '0;

        // Reset state, including ready suppressed while reset is held.
        #3;
        in_req_valid = 4'hF;
        #1;
        check_all_zero("reset");
        in_req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Single requester 0: ready same cycle, registered copy one cycle later.
        in_req_valid = 4'b0001;
        #1;
        check("single_ready", out_req_ready, 4'b0001);
        tick();
        check("single_pf_valid", out_partial_force_valid, 1);
        check("single_pf_id", out_particle_id, {4'd2, 4'd2, 4'd2, 9'd5});
        check("single_pf_force", out_partial_force, {3{32'h3F80_0000}});
        in_req_valid = '0;
        tick();
        check("idle_pf_valid", out_partial_force_valid, 0);
        check("idle_pf_id_hold", out_particle_id, {4'd2, 4'd2, 4'd2, 9'd5});

        // Table of arbitration vectors.
        for (int k = 0; k < 7; k++) begin
            in_req_valid = vecs[k].valid;
`ifdef FORCE_SCHED_ROUND_ROBIN_EN
            exp = vecs[k].exp_rr;
`else
            exp = vecs[k].exp_fixed;
`endif
            #1;
            $display("vec %0d valid=%b ready=%b expected=%b", k, in_req_valid, out_req_ready, exp);
            check("vec_ready", out_req_ready, exp);
            tick();
            check("vec_pf_valid", out_partial_force_valid, |exp);
            if (exp != '0) check("vec_pf_id", out_particle_id, tb_id[idx_of(exp)]);
        end

        // Eight cycles with every requester valid.
        in_req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
`ifdef FORCE_SCHED_ROUND_ROBIN_EN
            exp = 4'b0001 << (c % 4);
`else
            exp = 4'b0001;
`endif
            #1;
            $display("sweep %0d ready=%b expected=%b", c, out_req_ready, exp);
            check("sweep_ready", out_req_ready, exp);
            tick();
        end

        // Readout of 3 particles while requesters stay valid.
        in_start_readout  = 1'b1;
        in_particle_count = 9'd3;
        #1;
        check("start_ready_low", out_req_ready, 0);
        tick();
        in_start_readout  = 1'b0;
        in_particle_count = 9'd0;
        check("drain_busy", out_busy, 1);
        check("drain_first_pf_valid", out_partial_force_valid, 0);
        wait_drain(-1, n);
        $display("readout3 drain_cycles=%0d", n);
        check("drain3_len", n, 24);
        for (int a = 1; a <= 3; a++) begin
            check("rd3_req_addr", {out_read_data_request, out_cache_read_address}, {1'b1, 9'(a)});
            check("rd3_pf_valid", out_partial_force_valid, 0);
            tick();
        end
        check("rd3_done", {out_readout_done, out_read_data_request, out_busy}, 3'b101);
        tick();
        check("rd3_after_done", {out_readout_done, out_busy}, 2'b00);
        check("rd3_accum_grant", |out_req_ready, 1);

        // Count 0 with a second start pulse during DRAIN.
        in_start_readout  = 1'b1;
        in_particle_count = 9'd0;
        tick();
        in_start_readout  = 1'b0;
        wait_drain(5, n);
        $display("readout0 drain_cycles=%0d", n);
        check("drain0_len", n, 24);
        check("rd0_done", {out_readout_done, out_read_data_request}, 2'b10);
        tick();
        check("rd0_after_done", {out_readout_done, out_busy}, 2'b00);
        dones = 0;
        rds   = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_readout_done) dones++;
            if (out_read_data_request) rds++;
            tick();
        end
        check("rd0_no_second_done", dones, 0);
        check("rd0_no_second_read", rds, 0);

        // Reset asserted at readout address 2 of 5.
        in_start_readout  = 1'b1;
        in_particle_count = 9'd5;
        tick();
        in_start_readout  = 1'b0;
        wait_drain(-1, n);
        check("drain5_len", n, 24);
        check("rd5_addr1", out_cache_read_address, 1);
        tick();
        check("rd5_addr2", out_cache_read_address, 2);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        check("post_reset_busy", out_busy, 0);
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_readout_done) dones++;
            tick();
        end
        check("post_reset_no_done", dones, 0);
        check("post_reset_grant", |out_req_ready, 1);

        // Full-range count: addresses 1..511 without wrapping.
        in_start_readout  = 1'b1;
        in_particle_count = 9'h1FF;
        tick();
        in_start_readout  = 1'b0;
        wait_drain(-1, n);
        check("drain511_len", n, 24);
        for (int a = 1; a <= 511; a++) begin
            check("rd511_req_addr", {out_read_data_request, out_cache_read_address}, {1'b1, 9'(a)});
            tick();
        end
        check("rd511_done", {out_readout_done, out_read_data_request}, 2'b10);
        tick();
        check("rd511_accum", out_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
